// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types and default parameters for the Ethernet transmit arbiter.
package eth_arb_pkg;

    localparam int IFG_DIBITS_DEF    = 48;
    localparam int MAX_DIBITS_DEF    = 6104;
    localparam int START_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        XFER,
        DRAIN,
        GAP
    } state_t;

    typedef enum logic {
        SRC_CAM,
        SRC_CTL
    } src_t;

    // The round-robin pointer always moves to whichever source was not just served.
    function automatic src_t other_src(input src_t s);
        return (s == SRC_CAM) ? SRC_CTL : SRC_CAM;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Bundle of the two packet sources, the muxed RMII dibit stream and the status outputs.
interface eth_tx_arbiter_if;
    import eth_arb_pkg::*;

    logic       req_cam;
    logic       gnt_cam;
    logic       cam_axiiv;
    logic [1:0] cam_axiid;
    logic       req_ctl;
    logic       gnt_ctl;
    logic       ctl_axiiv;
    logic [1:0] ctl_axiid;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic [7:0] timeout_cnt;
    logic [7:0] trunc_cnt;

    // Source/networking side: drives requests and dibits, observes grants and the muxed stream.
    modport master (
        output req_cam, cam_axiiv, cam_axiid,
        output req_ctl, ctl_axiiv, ctl_axiid,
        input  gnt_cam, gnt_ctl, axiov, axiod, busy, timeout_cnt, trunc_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_cam, cam_axiiv, cam_axiid,
        input  req_ctl, ctl_axiiv, ctl_axiid,
        output gnt_cam, gnt_ctl, axiov, axiod, busy, timeout_cnt, trunc_cnt
    );

endinterface

// File: rtl/eth_tx_arbiter_sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping; cleared only by reset.
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);

    // Count single-cycle increment pulses, holding at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin packet arbiter sharing one 2-bit RMII transmit stream between the
// camera source and the control/status source, with inter-frame gap enforcement,
// start timeout and packet length truncation.
module eth_tx_arbiter
    import eth_arb_pkg::*;
#(
    parameter int IFG_DIBITS    = IFG_DIBITS_DEF,
    parameter int MAX_DIBITS    = MAX_DIBITS_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input logic            eth_refclk,
    input logic            rst,
    eth_tx_arbiter_if.slave bus
);

    localparam int LEN_W    = $clog2(MAX_DIBITS + 1);
    localparam int WAIT_MAX = (START_TIMEOUT > IFG_DIBITS) ? START_TIMEOUT : IFG_DIBITS;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    state_t            state;
    src_t              owner;
    src_t              rr_ptr;
    logic [LEN_W-1:0]  len_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              gnt_cam_q;
    logic              gnt_ctl_q;
    logic              axiov_q;
    logic [1:0]        axiod_q;

    logic              sel_req;
    logic              sel_valid;
    logic [1:0]        sel_data;
    logic              timeout_hit;
    logic              trunc_hit;

    // Only the granted source is ever looked at; the other one is ignored entirely.
    assign sel_req   = (owner == SRC_CAM) ? bus.req_cam   : bus.req_ctl;
    assign sel_valid = (owner == SRC_CAM) ? bus.cam_axiiv : bus.ctl_axiiv;
    assign sel_data  = (owner == SRC_CAM) ? bus.cam_axiid : bus.ctl_axiid;

    // A still-requesting source that never raised valid within the start window loses its grant.
    assign timeout_hit = (state == GRANT) && !sel_valid && sel_req &&
                         (wait_cnt == WAIT_W'(START_TIMEOUT - 1));

    // A dibit arriving after the maximum length has been forwarded cuts the packet.
    assign trunc_hit = (state == XFER) && sel_valid && (len_cnt == LEN_W'(MAX_DIBITS));

    // Arbitration FSM with registered grants and registered output mux.
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= SRC_CAM;
            rr_ptr    <= SRC_CAM;
            len_cnt   <= '0;
            wait_cnt  <= '0;
            gnt_cam_q <= 1'b0;
            gnt_ctl_q <= 1'b0;
            axiov_q   <= 1'b0;
            axiod_q   <= 2'b00;
        end else begin
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            case (state)
                IDLE: begin
                    len_cnt  <= '0;
                    wait_cnt <= '0;
                    if (bus.req_cam || bus.req_ctl) begin
                        state <= GRANT;
                        if (bus.req_cam && (!bus.req_ctl || (rr_ptr == SRC_CAM))) begin
                            owner     <= SRC_CAM;
                            gnt_cam_q <= 1'b1;
                            rr_ptr    <= other_src(SRC_CAM);
                        end else begin
                            owner     <= SRC_CTL;
                            gnt_ctl_q <= 1'b1;
                            rr_ptr    <= other_src(SRC_CTL);
                        end
                    end
                end
                GRANT: begin
                    if (sel_valid) begin
                        state   <= XFER;
                        axiov_q <= 1'b1;
                        axiod_q <= sel_data;
                        len_cnt <= LEN_W'(1);
                    end else if (!sel_req) begin
                        state     <= IDLE;
                        gnt_cam_q <= 1'b0;
                        gnt_ctl_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state     <= GAP;
                        wait_cnt  <= '0;
                        gnt_cam_q <= 1'b0;
                        gnt_ctl_q <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                XFER: begin
                    if (!sel_valid) begin
                        state     <= GAP;
                        wait_cnt  <= '0;
                        gnt_cam_q <= 1'b0;
                        gnt_ctl_q <= 1'b0;
                    end else if (trunc_hit) begin
                        state     <= DRAIN;
                        gnt_cam_q <= 1'b0;
                        gnt_ctl_q <= 1'b0;
                    end else begin
                        axiov_q <= 1'b1;
                        axiod_q <= sel_data;
                        len_cnt <= len_cnt + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (!sel_valid) begin
                        state    <= GAP;
                        wait_cnt <= '0;
                    end
                end
                GAP: begin
                    if (wait_cnt == WAIT_W'(IFG_DIBITS - 1)) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_cam_q <= 1'b0;
                    gnt_ctl_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_cam = gnt_cam_q;
    assign bus.gnt_ctl = gnt_ctl_q;
    assign bus.axiov   = axiov_q;
    assign bus.axiod   = axiod_q;
    assign bus.busy    = (state != IDLE);

    sat_counter8 u_timeout_cnt (
        .clk   (eth_refclk),
        .rst   (rst),
        .inc   (timeout_hit),
        .count (bus.timeout_cnt)
    );

    sat_counter8 u_trunc_cnt (
        .clk   (eth_refclk),
        .rst   (rst),
        .inc   (trunc_hit),
        .count (bus.trunc_cnt)
    );

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: table of grant vectors plus hand-written
// sequences for timeout, truncation, reset and cross-source isolation.
module tb_eth_tx_arbiter;
    import eth_arb_pkg::*;

    localparam int IFG  = 48;
    localparam int MAXD = 6104;
    localparam int TO   = 1024;

    typedef struct {
        logic req_cam;
        logic req_ctl;
        logic exp_cam;
        logic exp_ctl;
        int   n;
    } vec_t;

    logic eth_refclk = 1'b0;
    logic rst;

    eth_tx_arbiter_if bus ();

    eth_tx_arbiter #(
        .IFG_DIBITS    (IFG),
        .MAX_DIBITS    (MAXD),
        .START_TIMEOUT (TO)
    ) dut (
        .eth_refclk (eth_refclk),
        .rst        (rst),
        .bus        (bus)
    );

    // 50 MHz reference clock.
    always #10 eth_refclk = ~eth_refclk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         hi_count     = 0;
    int         idle_run     = 0;
    bit         seen_pkt     = 0;
    bit         prev_v       = 0;
    bit         mon_en       = 0;
    logic [1:0] exp_q[$];
    vec_t       vecs[9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard and stream rules, evaluated once per cycle just after the clock edge.
    task automatic monitor();
        logic [1:0] exp_d;
        if (!mon_en) return;
        if (rst) begin
            seen_pkt = 0;
            idle_run = 0;
            prev_v   = 0;
            return;
        end
        check_output("gnt_exclusive", 32'(bus.gnt_cam & bus.gnt_ctl), 0);
        if (bus.axiov === 1'b1) begin
            hi_count++;
            if (!prev_v && seen_pkt) check_output("ifg_min", 32'(idle_run >= IFG), 1);
            seen_pkt = 1;
            idle_run = 0;
            check_output("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check_output("axiod", 32'(bus.axiod), 32'(exp_d));
            end
        end else begin
            check_output("axiod_idle", 32'(bus.axiod), 0);
            idle_run++;
        end
        prev_v = (bus.axiov === 1'b1);
    endtask

    task automatic tick();
        @(posedge eth_refclk);
        #1;
        monitor();
    endtask

    task automatic idle_inputs();
        bus.req_cam   = 1'b0;
        bus.req_ctl   = 1'b0;
        bus.cam_axiiv = 1'b0;
        bus.cam_axiid = 2'b00;
        bus.ctl_axiiv = 1'b0;
        bus.ctl_axiid = 2'b00;
    endtask

    task automatic send_packet(input src_t src, input int n, input int push_limit,
                               input bit rand_data, input logic [1:0] fixed, input bit ctl_noise);
        logic [1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rand_data ? 2'($urandom_range(0, 3)) : fixed;
            if (src == SRC_CAM) begin
                bus.cam_axiiv = 1'b1;
                bus.cam_axiid = d;
                if (ctl_noise) begin
                    bus.ctl_axiiv = 1'b1;
                    bus.ctl_axiid = 2'b11;
                end
            end else begin
                bus.ctl_axiiv = 1'b1;
                bus.ctl_axiid = d;
            end
            if (i < push_limit) exp_q.push_back(d);
            tick();
        end
    endtask

    task automatic end_packet();
        int n;
        idle_inputs();
        tick();
        check_output("gnt_released", 32'({bus.gnt_cam, bus.gnt_ctl}), 0);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_output("gap_cycles", n, IFG);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.req_cam = v.req_cam;
        bus.req_ctl = v.req_ctl;
        tick();
        check_output("gnt_cam", 32'(bus.gnt_cam), 32'(v.exp_cam));
        check_output("gnt_ctl", 32'(bus.gnt_ctl), 32'(v.exp_ctl));
        check_output("busy_granted", 32'(bus.busy), 1);
        send_packet(v.exp_cam ? SRC_CAM : SRC_CTL, v.n, v.n, 1'b1, 2'b00, 1'b0);
        end_packet();
    endtask

    initial begin
        int n;
        int h0;

        // Grant vectors; the round-robin pointer starts at CAM after reset.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 12};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 20};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 20};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 20};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 5};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 20};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 3};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 20};

        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        check_output("rst_axiov", 32'(bus.axiov), 0);
        check_output("rst_axiod", 32'(bus.axiod), 0);
        check_output("rst_gnt_cam", 32'(bus.gnt_cam), 0);
        check_output("rst_gnt_ctl", 32'(bus.gnt_ctl), 0);
        check_output("rst_busy", 32'(bus.busy), 0);
        check_output("rst_timeout_cnt", 32'(bus.timeout_cnt), 0);
        check_output("rst_trunc_cnt", 32'(bus.trunc_cnt), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

        // Single camera packet: grant latency, forwarding latency, length and gap.
        bus.req_cam = 1'b1;
        tick();
        check_output("t1_gnt_cam", 32'(bus.gnt_cam), 1);
        check_output("t1_axiov_pre", 32'(bus.axiov), 0);
        h0 = hi_count;
        bus.cam_axiiv = 1'b1;
        bus.cam_axiid = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        check_output("t1_latency", 32'(bus.axiov), 1);
        send_packet(SRC_CAM, 99, 99, 1'b0, 2'b10, 1'b0);
        check_output("t1_len", hi_count - h0, 100);
        end_packet();

        // Control source drives valid while camera owns the path.
        bus.req_cam = 1'b1;
        tick();
        check_output("t6_gnt_cam", 32'(bus.gnt_cam), 1);
        bus.ctl_axiiv = 1'b1;
        bus.ctl_axiid = 2'b11;
        tick();
        check_output("t6_no_ctl_leak", 32'(bus.axiov), 0);
        h0 = hi_count;
        send_packet(SRC_CAM, 30, 30, 1'b0, 2'b01, 1'b1);
        check_output("t6_len", hi_count - h0, 30);
        end_packet();

        // Start timeout on the control source, with a camera request pending.
        bus.req_ctl = 1'b1;
        tick();
        check_output("t3_gnt_ctl", 32'(bus.gnt_ctl), 1);
        n = 0;
        while (bus.gnt_ctl === 1'b1 && n < 1100) begin
            if (n == 10) bus.req_cam = 1'b1;
            tick();
            n++;
        end
        check_output("t3_timeout_len", n, TO);
        check_output("t3_timeout_cnt", 32'(bus.timeout_cnt), 1);
        check_output("t3_busy_gap", 32'(bus.busy), 1);
        bus.req_ctl = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            check_output("t3_gap_no_gnt", 32'(bus.gnt_cam), 0);
            tick();
            n++;
        end
        check_output("t3_gap_cycles", n, IFG);
        tick();
        check_output("t3_pending_cam", 32'(bus.gnt_cam), 1);
        send_packet(SRC_CAM, 4, 4, 1'b1, 2'b00, 1'b0);
        end_packet();

        // Oversized camera packet is cut at the maximum length.
        bus.req_cam = 1'b1;
        tick();
        check_output("t4_gnt_cam", 32'(bus.gnt_cam), 1);
        h0 = hi_count;
        send_packet(SRC_CAM, 6200, MAXD, 1'b1, 2'b00, 1'b0);
        check_output("t4_len", hi_count - h0, MAXD);
        check_output("t4_trunc_cnt", 32'(bus.trunc_cnt), 1);
        check_output("t4_gnt_dropped", 32'(bus.gnt_cam), 0);
        check_output("t4_busy_drain", 32'(bus.busy), 1);
        end_packet();
        check_output("t4_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a camera transfer.
        bus.req_cam = 1'b1;
        tick();
        send_packet(SRC_CAM, 50, 50, 1'b1, 2'b00, 1'b0);
        rst = 1'b1;
        tick();
        check_output("t5_axiov", 32'(bus.axiov), 0);
        check_output("t5_axiod", 32'(bus.axiod), 0);
        check_output("t5_gnt_cam", 32'(bus.gnt_cam), 0);
        check_output("t5_gnt_ctl", 32'(bus.gnt_ctl), 0);
        check_output("t5_busy", 32'(bus.busy), 0);
        check_output("t5_timeout_cnt", 32'(bus.timeout_cnt), 0);
        check_output("t5_trunc_cnt", 32'(bus.trunc_cnt), 0);
        check_output("t5_sb_empty", exp_q.size(), 0);
        rst = 1'b0;
        idle_inputs();
        bus.req_cam = 1'b1;
        bus.req_ctl = 1'b1;
        tick();
        check_output("t5_rr_cam", 32'(bus.gnt_cam), 1);
        check_output("t5_rr_ctl", 32'(bus.gnt_ctl), 0);
        send_packet(SRC_CAM, 8, 8, 1'b1, 2'b00, 1'b0);
        end_packet();

        check_output("final_sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
